// File: rtl/jk_flip_flop.sv
// Purpose : bank of WIDTH independent positive-edge JK flip-flops with complementary outputs.
// Latency : one CLK rising edge from J/K/RST (and PRE) sampling to Q/Qnot; no comb path in->out.
// Backpr. : none; every rising edge samples the inputs. Optional synchronous preset via JK_FLIPFLOP_PRESET_EN.
module jk_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
`ifdef JK_FLIPFLOP_PRESET_EN
  input  logic [WIDTH-1:0] PRE,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot
);

  // Single state register; Qnot is derived from it so the pair can never disagree.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  // Per-bit JK next-state rule, preset (when built in) overriding J/K.
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({J[i], K[i]})
        2'b00:   w_q_next[i] = r_q[i];
        2'b10:   w_q_next[i] = 1'b1;
        2'b01:   w_q_next[i] = 1'b0;
        2'b11:   w_q_next[i] = ~r_q[i];
        default: w_q_next[i] = r_q[i];
      endcase
`ifdef JK_FLIPFLOP_PRESET_EN
      if (PRE[i]) begin
        w_q_next[i] = 1'b1;
      end
`endif
    end
  end

  // State update on the rising edge; reset wins over preset and J/K.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign Q    = r_q;
  assign Qnot = ~r_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
module tb_jk_flip_flop;

  localparam int         W   = 2;
  localparam logic [1:0] RV2 = 2'b10;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] J   = 2'b00;
  logic [1:0] K   = 2'b00;
  logic [1:0] PRE = 2'b00;
  logic [1:0] q_a, qn_a, q_b, qn_b;

  always #5 CLK = ~CLK;

  jk_flip_flop #(.WIDTH(W)) dut_a (
    .CLK(CLK), .RST(RST), .J(J), .K(K),
`ifdef JK_FLIPFLOP_PRESET_EN
    .PRE(PRE),
`endif
    .Q(q_a), .Qnot(qn_a)
  );

  jk_flip_flop #(.WIDTH(W), .RESET_VALUE(RV2)) dut_b (
    .CLK(CLK), .RST(RST), .J(J), .K(K),
`ifdef JK_FLIPFLOP_PRESET_EN
    .PRE(PRE),
`endif
    .Q(q_b), .Qnot(qn_b)
  );

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_a = 2'bxx;
  logic [1:0] m_b = 2'bxx;
  int         n_chk  = 0;
  int         n_fail = 0;

  // Reference model of one bank.
  function automatic logic [1:0] model_next(input logic [1:0] q, input logic [1:0] j,
                                            input logic [1:0] k, input logic rst,
                                            input logic [1:0] rv, input logic [1:0] pre);
    logic [1:0] n;
    if (rst) return rv;
    for (int i = 0; i < 2; i++) begin
      if (pre[i])                n[i] = 1'b1;
      else if (j[i] && k[i])     n[i] = ~q[i];
      else if (j[i])             n[i] = 1'b1;
      else if (k[i])             n[i] = 1'b0;
      else                       n[i] = q[i];
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    check({tag, ".Qa"},    q_a,  ea);
    check({tag, ".Qnota"}, qn_a, ~ea);
    check({tag, ".Qb"},    q_b,  eb);
    check({tag, ".Qnotb"}, qn_b, ~eb);
  endtask

  // One rising edge: optional glitching of J/K away from the edge, then real inputs,
  // expectation pushed at drive time, popped and compared just after the edge.
  task automatic step(input string tag, input logic [1:0] jv, input logic [1:0] kv,
                      input logic rst, input logic [1:0] pv, input bit glitch);
    exp_t e;
    exp_t got;
    @(negedge CLK);
    if (glitch) begin
      J = 2'($urandom);
      K = 2'($urandom);
      #1;
      check_all({tag, ".low"}, m_a, m_b);
      #1;
    end
    J = jv; K = kv; RST = rst; PRE = pv;
    m_a = model_next(m_a, jv, kv, rst, 2'b00, pv);
    m_b = model_next(m_b, jv, kv, rst, RV2, pv);
    e.a = m_a;
    e.b = m_b;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    got = sb.pop_front();
    check_all(tag, got.a, got.b);
    if (glitch) begin
      J = 2'($urandom);
      K = 2'($urandom);
      RST = 1'($urandom);
      #2;
      check_all({tag, ".high"}, m_a, m_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset overrides toggle; second reset edge keeps the reset value.
    step("rst0", 2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
    step("rst1", 2'b11, 2'b00, 1'b1, 2'b00, 1'b0);
    // Set / clear, with bits driven differently to show independence.
    step("set0",  2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
    step("clr0",  2'b00, 2'b01, 1'b0, 2'b00, 1'b0);
    step("set1",  2'b10, 2'b01, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step("hold", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    // Toggle from a known 00 state: 1,0,1,0 on every bit.
    step("clrall", 2'b00, 2'b11, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) step("tog", 2'b11, 2'b11, 1'b0, 2'b00, 1'b0);
    // Mid-toggle reset when Q=1, then toggling resumes.
    step("tog_up", 2'b11, 2'b11, 1'b0, 2'b00, 1'b0);
    step("midrst", 2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
    step("resume", 2'b11, 2'b11, 1'b0, 2'b00, 1'b0);
`ifdef JK_FLIPFLOP_PRESET_EN
    step("pre_clr", 2'b00, 2'b11, 1'b0, 2'b00, 1'b0);
    step("pre",     2'b00, 2'b11, 1'b0, 2'b01, 1'b0);
    step("pre_tog", 2'b11, 2'b11, 1'b0, 2'b11, 1'b0);
    step("pre_rst", 2'b00, 2'b00, 1'b1, 2'b11, 1'b0);
`endif
    // Random sweep with J/K/RST glitches in both clock phases: 160 cycles = 320 half-cycles.
    for (int i = 0; i < 160; i++) begin
      step("sweep", 2'($urandom), 2'($urandom), ($urandom_range(0, 15) == 0), 2'b00, 1'b1);
    end
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
